// File: rtl/vga_timing_controller.sv
// VGA raster timing: pixel-tick divider, free-running h/v counters, a sync/blank delay
// line matched to renderer latency, and a blanking-gated registered RGB output.
module vga_timing_controller #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SYNC_ACTIVE = 0,
  parameter int CLK_DIV     = 1,
  parameter int PIPE_DELAY  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] vga_data,
  output logic [11:0] h_cnt,
  output logic [11:0] v_cnt,
  output logic        pix_tick,
  output logic        frame_start,
  output logic        video_on,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [1:0]  DIV_LAST = 2'(CLK_DIV - 1);

  localparam logic       SYNC_ON    = (SYNC_ACTIVE != 0);
  localparam logic       SYNC_OFF   = ~SYNC_ON;
  localparam logic [2:0] STAGE_IDLE = {SYNC_OFF, SYNC_OFF, 1'b0};

  logic [1:0]                div_q, div_d;
  logic                      tick_q, tick_d;
  logic [11:0]               h_q, h_d;
  logic [11:0]               v_q, v_d;
  logic                      fs_q, fs_d;
  logic                      von_q, von_d;
  logic [PIPE_DELAY:0][2:0]  stg_q, stg_d;
  logic [11:0]               rgb_q, rgb_d;
  logic                      hs_raw_s, vs_raw_s, act_dly_s, act_out_s;

  assign hs_raw_s = ((h_q >= HS_START) && (h_q < HS_END)) ? SYNC_ON : SYNC_OFF;
  assign vs_raw_s = ((v_q >= VS_START) && (v_q < VS_END)) ? SYNC_ON : SYNC_OFF;

  // Colour is gated by the active flag aged PIPE_DELAY ticks, matching when vga_data arrives.
  generate
    if (PIPE_DELAY == 0) begin : g_no_dly
      assign act_dly_s = von_q;
    end else begin : g_dly
      assign act_dly_s = stg_q[PIPE_DELAY-1][0];
    end
  endgenerate

  // Next-state logic: divider, counters, delay line and colour register.
  always_comb begin
    div_d  = (div_q == DIV_LAST) ? 2'd0 : div_q + 2'd1;
    tick_d = (div_d == DIV_LAST);
    h_d    = h_q;
    v_d    = v_q;
    stg_d  = stg_q;
    rgb_d  = rgb_q;
    if (tick_q) begin
      if (h_q == H_LAST) begin
        h_d = 12'd0;
        if (v_q == V_LAST) begin
          v_d = 12'd0;
        end else begin
          v_d = v_q + 12'd1;
        end
      end else begin
        h_d = h_q + 12'd1;
      end
      stg_d    = stg_q << 3;
      stg_d[0] = {hs_raw_s, vs_raw_s, von_q};
      rgb_d    = act_dly_s ? vga_data : 12'd0;
    end else begin
      h_d   = h_q;
      v_d   = v_q;
      stg_d = stg_q;
      rgb_d = rgb_q;
    end
    von_d = (h_d < H_ACT) && (v_d < V_ACT);
    fs_d  = tick_d && (h_d == 12'd0) && (v_d == 12'd0);
  end

  // State registers with synchronous reset; reset abandons the frame and restarts at 0,0.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= 2'd0;
      tick_q <= 1'b0;
      h_q    <= 12'd0;
      v_q    <= 12'd0;
      fs_q   <= 1'b0;
      von_q  <= 1'b1;
      stg_q  <= {(PIPE_DELAY+1){STAGE_IDLE}};
      rgb_q  <= 12'd0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
      h_q    <= h_d;
      v_q    <= v_d;
      fs_q   <= fs_d;
      von_q  <= von_d;
      stg_q  <= stg_d;
      rgb_q  <= rgb_d;
    end
  end

  // The last-stage active flag always matches the colour register's gate; it doubles as a blanking guard.
  assign act_out_s   = stg_q[PIPE_DELAY][0];
  assign h_cnt       = h_q;
  assign v_cnt       = v_q;
  assign pix_tick    = tick_q;
  assign frame_start = fs_q;
  assign video_on    = von_q;
  assign hsync       = stg_q[PIPE_DELAY][2];
  assign vsync       = stg_q[PIPE_DELAY][1];
  assign vga_r       = act_out_s ? rgb_q[11:8] : 4'd0;
  assign vga_g       = act_out_s ? rgb_q[7:4]  : 4'd0;
  assign vga_b       = act_out_s ? rgb_q[3:0]  : 4'd0;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Bench for vga_timing_controller: two small-geometry instances (divider 1 / delay 1 and
// divider 4 / delay 2, opposite sync polarity) checked every cycle against an arithmetic model.
module tb_vga_timing_controller;

  localparam int HA = 16, HF = 2, HS = 3, HB = 4;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [11:0] vd0, vd1;
  logic [11:0] h0, v0, h1, v1;
  logic        tk0, fs0, von0, hs0, vs0;
  logic        tk1, fs1, von1, hs1, vs1;
  logic [3:0]  u0_r, u0_g, u0_b, u1_r, u1_g, u1_b;

  int nchk = 0;
  int nerr = 0;

  // Model state: m = clocks since reset release, t = pixel ticks completed since reset.
  int          m [2];
  int          t [2];
  logic [11:0] hist [2][8];
  bit          valid = 1'b0;
  int          div_of [2] = '{1, 4};
  int          pd_of  [2] = '{1, 2};
  int          sa_of  [2] = '{0, 1};

  vga_timing_controller #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_ACTIVE(0), .CLK_DIV(1), .PIPE_DELAY(1)
  ) u0 (
    .clk(clk), .rst(rst), .vga_data(vd0), .h_cnt(h0), .v_cnt(v0), .pix_tick(tk0),
    .frame_start(fs0), .video_on(von0), .hsync(hs0), .vsync(vs0),
    .vga_r(u0_r), .vga_g(u0_g), .vga_b(u0_b)
  );

  vga_timing_controller #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_ACTIVE(1), .CLK_DIV(4), .PIPE_DELAY(2)
  ) u1 (
    .clk(clk), .rst(rst), .vga_data(vd1), .h_cnt(h1), .v_cnt(v1), .pix_tick(tk1),
    .frame_start(fs1), .video_on(von1), .hsync(hs1), .vsync(vs1),
    .vga_r(u1_r), .vga_g(u1_g), .vga_b(u1_b)
  );

  function automatic bit act_at(input int p);
    return ((p % HT) < HA) && (((p / HT) % VT) < VA);
  endfunction

  function automatic bit hraw_at(input int p);
    int h;
    h = p % HT;
    return (h >= HA + HF) && (h < HA + HF + HS);
  endfunction

  function automatic bit vraw_at(input int p);
    int v;
    v = (p / HT) % VT;
    return (v >= VA + VF) && (v < VA + VF + VS);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_inst(input int i, input logic [11:0] h, input logic [11:0] v,
                            input logic tk, input logic fs, input logic von,
                            input logic hs, input logic vs, input logic [11:0] rgb);
    int tt, p, q, ergb;
    bit on, etk;
    tt  = t[i];
    on  = (sa_of[i] != 0);
    etk = (m[i] >= 1) && ((m[i] % div_of[i]) == div_of[i] - 1);
    chk($sformatf("u%0d.pix_tick", i), int'(tk), int'(etk));
    chk($sformatf("u%0d.h_cnt", i), int'(h), tt % HT);
    chk($sformatf("u%0d.v_cnt", i), int'(v), (tt / HT) % VT);
    chk($sformatf("u%0d.frame_start", i), int'(fs), int'(etk && ((tt % (HT * VT)) == 0)));
    chk($sformatf("u%0d.video_on", i), int'(von), int'(act_at(tt)));
    p = tt - pd_of[i] - 1;
    chk($sformatf("u%0d.hsync", i), int'(hs), int'((p >= 0 && hraw_at(p)) ? on : !on));
    chk($sformatf("u%0d.vsync", i), int'(vs), int'((p >= 0 && vraw_at(p)) ? on : !on));
    q = tt - 1;
    p = q - pd_of[i];
    ergb = (q >= 0 && p >= 0 && act_at(p)) ? int'(hist[i][q % 8]) : 0;
    chk($sformatf("u%0d.rgb", i), int'(rgb), ergb);
  endtask

  int cyc = 0;
  int fall0 = -1;
  int fs_last0 = -1;
  int line_last1 = -1;
  bit hs_prev0 = 1'b1;

  // Compare process: check outputs at the falling edge, then advance the model with the
  // inputs that the next rising edge will sample.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (valid) begin
        check_inst(0, h0, v0, tk0, fs0, von0, hs0, vs0, {u0_r, u0_g, u0_b});
        check_inst(1, h1, v1, tk1, fs1, von1, hs1, vs1, {u1_r, u1_g, u1_b});
        if (m[0] == 0) begin
          chk("rst.h_cnt0", int'(h0), 0);
          chk("rst.hsync0", int'(hs0), 1);
          chk("rst.rgb0", int'({u0_r, u0_g, u0_b}), 0);
          chk("rst.hsync1", int'(hs1), 0);
        end
        if (hs_prev0 && !hs0) begin
          if (fall0 >= 0) chk("line_period0", cyc - fall0, 25);
          fall0 = cyc;
        end
        if (!hs_prev0 && hs0 && fall0 >= 0) chk("hsync_width0", cyc - fall0, 3);
        if (fs0) begin
          if (fs_last0 >= 0) chk("frame_period0", cyc - fs_last0, 250);
          fs_last0 = cyc;
        end
        if (tk1 && h1 == 12'd0) begin
          if (line_last1 >= 0) chk("line_period1", cyc - line_last1, 100);
          line_last1 = cyc;
        end
        if (tk1 && v1 < 12'(VA)) begin
          if (h1 == 12'd3)  chk("align_first1", int'({u1_r, u1_g, u1_b}), 12'h000);
          if (h1 == 12'd18) chk("align_last1",  int'({u1_r, u1_g, u1_b}), 12'h00F);
          if (h1 == 12'd19) chk("align_blank1", int'({u1_r, u1_g, u1_b}), 12'h000);
        end
        hs_prev0 = hs0;
      end
      if (rst) begin
        fall0 = -1;
        fs_last0 = -1;
        line_last1 = -1;
      end
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          m[i] = 0;
          t[i] = 0;
        end else if (valid) begin
          if (m[i] >= 1 && (m[i] % div_of[i]) == div_of[i] - 1) begin
            hist[i][t[i] % 8] = (i == 0) ? vd0 : vd1;
            t[i]++;
          end
          m[i]++;
        end
      end
      if (rst) valid = 1'b1;
    end
  end

  // Stimulus: random colour (with a constant-white window), a renderer model echoing
  // h_cnt two ticks late for u1, and three mid-frame 3-clock resets.
  initial begin
    int r0;
    rst = 1'b1;
    vd0 = 12'd0;
    vd1 = 12'd0;
    r0  = 4700 + $urandom_range(0, 3);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 6000; k++) begin
      @(posedge clk);
      #1;
      rst = (k >= 1500 && k < 1503) || (k >= 3203 && k < 3206) || (k >= r0 && k < r0 + 3);
      vd0 = (k >= 2000 && k < 2600) ? 12'hFFF : 12'($urandom);
      vd1 = (t[1] >= 2) ? 12'((t[1] - 2) % HT) : 12'd0;
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
